// File: rtl/jt12_mod_pipe_if.sv
// Slot-interface bundle for jt12_mod_pipe: the operator pipeline drives the slot
// inputs, and the modulation engine returns the registered modulation and slot position.
interface jt12_mod_pipe_if #(
    parameter int OPW = 14,
    parameter int NCH = 6
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic                  clk_en;
    logic [2:0]            alg;
    logic [2:0]            fb;
    logic signed [OPW-1:0] op_result;
    logic signed [OPW:0]   mod_out;
    logic [CHW-1:0]        cur_ch;
    logic [1:0]            cur_stage;
    logic                  zero;
    logic                  mod_valid;

    modport master (
        output clk_en, alg, fb, op_result,
        input  mod_out, cur_ch, cur_stage, zero, mod_valid
    );

    modport slave (
        input  clk_en, alg, fb, op_result,
        output mod_out, cur_ch, cur_stage, zero, mod_valid
    );
endinterface

// File: rtl/jt12_mod_pipe.sv
// FM operator-modulation engine: walks the slot sequence, keeps per-channel operator history
// and registers the phase-modulation input per algorithm. Macro JT12_MOD_CLAMP_EN enables clamping.
module jt12_mod_pipe #(
    parameter int OPW     = 14,
    parameter int NCH     = 6,
    parameter int FBSHIFT = 10
) (
    input  logic           clk,
    input  logic           rst,
    jt12_mod_pipe_if.slave bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

    // Hardware slot order within one sample.
    typedef enum logic [1:0] {S1 = 2'd0, S3 = 2'd1, S2 = 2'd2, S4 = 2'd3} stage_t;

    stage_t         stage;
    logic [CHW-1:0] ch;
    stage_t         nxt_stage, prv_stage;
    logic [CHW-1:0] nxt_ch, prv_ch;

    logic signed [OPW-1:0] h0  [NCH];
    logic signed [OPW-1:0] h1  [NCH];
    logic signed [OPW-1:0] op2 [NCH];
    logic signed [OPW-1:0] op3 [NCH];

    logic signed [OPW:0] mod_q, mod_nxt, sum;
    logic signed [OPW:0] x_h0, x_h1, x_op2, x_op3;
    logic [5:0]          fb_shift;
    logic                mod_valid_q;

    always_comb begin
        nxt_ch    = (ch == LAST_CH) ? '0 : ch + 1'b1;
        nxt_stage = (ch == LAST_CH) ? stage_t'(stage + 2'd1) : stage;
        prv_ch    = (ch == '0) ? LAST_CH : ch - 1'b1;
        prv_stage = (ch == '0) ? stage_t'(stage - 2'd1) : stage;
    end

    // Operands are read for the slot about to start; the channel written this cycle is a different one.
    always_comb begin
        x_h0     = {h0[nxt_ch][OPW-1], h0[nxt_ch]};
        x_h1     = {h1[nxt_ch][OPW-1], h1[nxt_ch]};
        x_op2    = {op2[nxt_ch][OPW-1], op2[nxt_ch]};
        x_op3    = {op3[nxt_ch][OPW-1], op3[nxt_ch]};
        fb_shift = 6'(FBSHIFT) - {3'b000, bus.fb};
        sum      = '0;
        case (nxt_stage)
            S1: if (bus.fb != 3'd0) sum = (x_h0 + x_h1) >>> fb_shift;
            S3: case (bus.alg)
                    3'd0, 3'd2: sum = x_op2;
                    3'd1:       sum = x_h0 + x_op2;
                    3'd5:       sum = x_h0;
                    default:    sum = '0;
                endcase
            S2: case (bus.alg)
                    3'd0, 3'd3, 3'd4, 3'd5, 3'd6: sum = x_h0;
                    default:                      sum = '0;
                endcase
            S4: case (bus.alg)
                    3'd0, 3'd1, 3'd4: sum = x_op3;
                    3'd2:             sum = x_h0 + x_op3;
                    3'd3:             sum = x_op2 + x_op3;
                    3'd5:             sum = x_h0;
                    default:          sum = '0;
                endcase
            default: sum = '0;
        endcase
    end

`ifdef JT12_MOD_CLAMP_EN
    localparam logic signed [OPW:0] MOD_MAX = {2'b00, {(OPW-1){1'b1}}};
    localparam logic signed [OPW:0] MOD_MIN = {2'b11, {(OPW-1){1'b0}}};

    always_comb begin
        if (sum > MOD_MAX)      mod_nxt = MOD_MAX;
        else if (sum < MOD_MIN) mod_nxt = MOD_MIN;
        else                    mod_nxt = sum;
    end
`else
    assign mod_nxt = sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            stage       <= S1;
            ch          <= '0;
            mod_q       <= '0;
            mod_valid_q <= 1'b0;
            // NOTE: history is cleared on reset because a mid-sample reset must discard it.
            for (int i = 0; i < NCH; i++) begin
                h0[i]  <= '0;
                h1[i]  <= '0;
                op2[i] <= '0;
                op3[i] <= '0;
            end
        end else if (bus.clk_en) begin
            stage       <= nxt_stage;
            ch          <= nxt_ch;
            mod_q       <= mod_nxt;
            mod_valid_q <= 1'b1;
            // op_result belongs to the slot that just ended.
            case (prv_stage)
                S1: begin
                    h1[prv_ch] <= h0[prv_ch];
                    h0[prv_ch] <= bus.op_result;
                end
                S2:      op2[prv_ch] <= bus.op_result;
                S3:      op3[prv_ch] <= bus.op_result;
                default: ;
            endcase
        end
    end

    assign bus.mod_out   = mod_q;
    assign bus.mod_valid = mod_valid_q;
    assign bus.cur_ch    = ch;
    assign bus.cur_stage = stage;
    assign bus.zero      = (stage == S1) && (ch == '0);
endmodule

// File: tb/tb_jt12_mod_pipe.sv
// Self-checking bench for jt12_mod_pipe: a slot-level reference model pushes expected
// modulation values to a queue, popped and compared when the DUT registers them.
module tb_jt12_mod_pipe;
    localparam int OPW     = 14;
    localparam int NCH     = 6;
    localparam int FBSHIFT = 10;
    localparam int NSLOT   = 4 * NCH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    jt12_mod_pipe_if #(.OPW(OPW), .NCH(NCH)) bus ();

    jt12_mod_pipe #(.OPW(OPW), .NCH(NCH), .FBSHIFT(FBSHIFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int m_cnt, last_exp, zero_cnt;
    int m_h0[NCH], m_h1[NCH], m_op2[NCH], m_op3[NCH];
    int ops_tbl[4][NCH];
    int got_mod[4][NCH];

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_mod(int stg, int c, int a, int f);
        int s = 0;
        case (stg)
            0: if (f != 0) s = (m_h0[c] + m_h1[c]) >>> (FBSHIFT - f);
            1: case (a)
                   0, 2: s = m_op2[c];
                   1:    s = m_h0[c] + m_op2[c];
                   5:    s = m_h0[c];
                   default: s = 0;
               endcase
            2: if (a inside {0, 3, 4, 5, 6}) s = m_h0[c];
            default: case (a)
                   0, 1, 4: s = m_op3[c];
                   2:       s = m_h0[c] + m_op3[c];
                   3:       s = m_op2[c] + m_op3[c];
                   5:       s = m_h0[c];
                   default: s = 0;
               endcase
        endcase
`ifdef JT12_MOD_CLAMP_EN
        if (s > 8191) s = 8191;
        if (s < -8192) s = -8192;
`endif
        return s;
    endfunction

    task automatic step(input logic en, input int a, input int f, input int op);
        int nxt, prv, e;
        bus.clk_en    = en;
        bus.alg       = 3'(a);
        bus.fb        = 3'(f);
        bus.op_result = OPW'(op);
        if (en) begin
            nxt = (m_cnt + 1) % NSLOT;
            prv = (m_cnt + NSLOT - 1) % NSLOT;
            exp_q.push_back(model_mod(nxt / NCH, nxt % NCH, a, f));
            case (prv / NCH)
                0: begin m_h1[prv % NCH] = m_h0[prv % NCH]; m_h0[prv % NCH] = op; end
                2: m_op2[prv % NCH] = op;
                1: m_op3[prv % NCH] = op;
                default: ;
            endcase
            m_cnt = nxt;
        end
        @(posedge clk);
        #1;
        if (en) begin
            e = exp_q.pop_front();
            check("mod_out", int'(bus.mod_out), e);
            check("mod_valid", int'(bus.mod_valid), 1);
            last_exp = e;
            got_mod[bus.cur_stage][bus.cur_ch] = int'(bus.mod_out);
            if (bus.zero) zero_cnt++;
        end else begin
            check("hold_mod", int'(bus.mod_out), last_exp);
        end
        check("cur_ch", int'(bus.cur_ch), m_cnt % NCH);
        check("cur_stage", int'(bus.cur_stage), m_cnt / NCH);
        check("zero", int'(bus.zero), int'(m_cnt == 0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mod", int'(bus.mod_out), 0);
        check("rst_valid", int'(bus.mod_valid), 0);
        check("rst_zero", int'(bus.zero), 1);
        check("rst_ch", int'(bus.cur_ch), 0);
        check("rst_stage", int'(bus.cur_stage), 0);
        rst = 1'b0;
        m_cnt = 0;
        last_exp = 0;
        zero_cnt = 0;
        exp_q.delete();
        for (int i = 0; i < NCH; i++) begin
            m_h0[i] = 0; m_h1[i] = 0; m_op2[i] = 0; m_op3[i] = 0;
        end
    endtask

    task automatic clear_tbl();
        for (int s = 0; s < 4; s++)
            for (int c = 0; c < NCH; c++) ops_tbl[s][c] = 0;
    endtask

    // Table operators: op_result for the slot that just ended comes from ops_tbl.
    task automatic run_slots(input int n, input int a, input int f);
        int prv;
        for (int i = 0; i < n; i++) begin
            prv = (m_cnt + NSLOT - 1) % NSLOT;
            step(1'b1, a, f, ops_tbl[prv / NCH][prv % NCH]);
        end
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, int'($urandom_range(7)), int'($urandom_range(7)),
                 int'($urandom_range(16383)) - 8192);
    endtask

    initial begin
        bus.clk_en = 1'b0;
        bus.alg = '0;
        bus.fb = '0;
        bus.op_result = '0;

        // Mid-sample reset discards history and restarts at S1 ch0.
        do_reset();
        run_random(30);
        do_reset();
        run_slots(48, 0, 0);
        check("zero_pulses", zero_cnt, 2);

        // alg 0 chain on ch0.
        do_reset();
        clear_tbl();
        ops_tbl[0][0] = 100; ops_tbl[1][0] = 7; ops_tbl[2][0] = 200;
        run_slots(NSLOT, 0, 0);
        check("a0_s2_ch0", got_mod[2][0], 100);
        check("a0_s4_ch0", got_mod[3][0], 7);
        run_slots(NSLOT, 0, 0);
        check("a0_s3_prev_op2", got_mod[1][0], 200);

        // alg 3 on ch2.
        do_reset();
        clear_tbl();
        ops_tbl[0][2] = 50; ops_tbl[2][2] = -30; ops_tbl[1][2] = 20;
        run_slots(NSLOT, 3, 0);
        check("a3_s4_ch2", got_mod[3][2], -10);
        check("a3_s2_ch2", got_mod[2][2], 50);

        // Feedback levels on ch1 with h0=h1=1000.
        do_reset();
        clear_tbl();
        ops_tbl[0][1] = 1000;
        run_slots(2 * NSLOT, 1, 0);
        check("fb0_s1", got_mod[0][1], 0);
        run_slots(NSLOT, 1, 7);
        check("fb7_s1", got_mod[0][1], 250);
        run_slots(NSLOT, 1, 1);
        check("fb1_s1", got_mod[0][1], 3);

        // Full-scale alg 2 sum on ch3.
        do_reset();
        clear_tbl();
        ops_tbl[0][3] = 8191; ops_tbl[1][3] = 8191;
        run_slots(NSLOT, 2, 0);
`ifdef JT12_MOD_CLAMP_EN
        check("a2_s4_max", got_mod[3][3], 8191);
`else
        check("a2_s4_max", got_mod[3][3], 16382);
`endif

        // clk_en low mid-sample: everything holds, no history write.
        do_reset();
        run_random(37);
        for (int i = 0; i < 10; i++)
            step(1'b0, int'($urandom_range(7)), int'($urandom_range(7)),
                 int'($urandom_range(16383)) - 8192);
        run_random(48);

        // Random traffic across all algorithms and feedback levels.
        run_random(200);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
